// File: rtl/line_buf_ctrl.sv
// Line-buffer controller: streams one feature map into a row FIFO and reads
// back the previous row as each new row arrives, then drains the last row.
module line_buf_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IFM_WIDTH  = 8,
  parameter int ROW_W      = 8,
  localparam int COL_W     = (IFM_WIDTH > 1) ? $clog2(IFM_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_W-1:0]      num_rows,
  input  logic                  ifm_valid,
  input  logic [DATA_WIDTH-1:0] ifm_data,
  output logic                  ifm_ready,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_wr_inc,
  output logic                  fifo_rd_inc,
  output logic                  fifo_wr_clr,
  output logic                  fifo_rd_clr,
  output logic                  busy,
  output logic                  done,
  output logic [ROW_W-1:0]      cur_row,
  output logic [COL_W-1:0]      cur_col
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IFM_WIDTH - 1);

  state_t                state_q, state_nx;
  logic [ROW_W-1:0]      rows_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic [COL_W-1:0]      flush_cnt_q;
  logic [DATA_WIDTH-1:0] pix_q;
  logic                  flush_done_q;
  logic                  accept;
  logic                  col_last;
  logic                  start_acc;
  logic                  flush_last;

  assign ifm_ready   = (state_q == FILL) || (state_q == STREAM);
  assign busy        = (state_q != IDLE);
  assign accept      = ifm_valid && ifm_ready;
  assign col_last    = (col_q == COL_LAST);
  assign fifo_wr_inc = rst_n;
  assign fifo_rd_inc = rst_n;
  assign cur_row     = row_q;
  assign cur_col     = col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx   = state_q;
    start_acc  = 1'b0;
    flush_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = FILL;
        end
      end
      FILL: begin
        if (accept && col_last)
          state_nx = (rows_q <= ROW_W'(1)) ? FLUSH : STREAM;
      end
      STREAM: begin
        if (accept && col_last && (row_q == rows_q - ROW_W'(1)))
          state_nx = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt_q == COL_LAST) begin
          flush_last = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (start_acc) begin
        rows_q      <= (num_rows == '0) ? ROW_W'(1) : num_rows;
        row_q       <= '0;
        col_q       <= '0;
        flush_cnt_q <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (state_q == FLUSH)
        flush_cnt_q <= flush_last ? '0 : flush_cnt_q + COL_W'(1);
    end
  end

  // Pixel is staged one cycle so fifo_data trails fifo_wr_en by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q        <= '0;
      fifo_data    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      fifo_wr_clr  <= 1'b0;
      fifo_rd_clr  <= 1'b0;
      flush_done_q <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (accept)     pix_q     <= ifm_data;
      if (fifo_wr_en) fifo_data <= pix_q;
      fifo_wr_en   <= accept;
      fifo_rd_en   <= (accept && (state_q == STREAM)) || (state_q == FLUSH);
      fifo_wr_clr  <= start_acc;
      fifo_rd_clr  <= start_acc;
      flush_done_q <= flush_last;
      done         <= flush_done_q;
    end
  end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, pixel width; IFM_WIDTH, default 8, pixels per row; ROW_W, default 8, row-counter width.
REQ-002 clk  input  1  single clock; all logic SHALL use its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  single-cycle pulse that begins one feature map.
REQ-005 num_rows  input  ROW_W  rows in the feature map; SHALL be sampled only on an accepted start.
REQ-006 ifm_valid  input  1  upstream pixel valid.
REQ-007 ifm_data  input  DATA_WIDTH  upstream pixel.
REQ-008 ifm_ready  output  1  pixel accepted when ifm_valid and ifm_ready are both high.
REQ-009 fifo_wr_en, fifo_rd_en  output  1 each  row-FIFO write and read enables.
REQ-010 fifo_data  output  DATA_WIDTH  row-FIFO write data.
REQ-011 fifo_wr_inc, fifo_rd_inc  output  1 each  row-FIFO pointer increments.
REQ-012 fifo_wr_clr, fifo_rd_clr  output  1 each  row-FIFO pointer clears.
REQ-013 busy, done  output  1 each  frame in progress; frame complete.
REQ-014 cur_row  output  ROW_W  current row; cur_col  output  clog2(IFM_WIDTH)  current column.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, FILL, STREAM, FLUSH.
REQ-016 IDLE: start=1 SHALL latch num_rows, clear row/col, pulse fifo_wr_clr and fifo_rd_clr high for exactly the next cycle, and move to FILL.
REQ-017 A start seen outside IDLE SHALL be ignored.
REQ-018 ifm_ready SHALL be 1 only in FILL and STREAM (combinational from state).
REQ-019 FILL: each accept SHALL increment col; an accept at col=IFM_WIDTH-1 SHALL set col=0 and row=1, then go to STREAM, or to FLUSH if latched num_rows<=1.
REQ-020 STREAM: each accept SHALL increment col; an accept at col=IFM_WIDTH-1 SHALL wrap col to 0 and increment row.
REQ-021 STREAM: the wrapping accept of row num_rows-1 SHALL go to FLUSH.
REQ-022 Write timing: an accept in cycle N SHALL give fifo_wr_en=1 in cycle N+1 and fifo_data=that pixel in cycle N+2; wr_en leads data by one cycle to match the FIFO's internal write-enable register.
REQ-023 fifo_data SHALL hold its value when no new data is due.
REQ-024 Read timing: each accept in STREAM SHALL give fifo_rd_en=1 in cycle N+1; FILL accepts SHALL NOT generate reads.
REQ-025 FLUSH: fifo_rd_en SHALL be 1 for exactly IFM_WIDTH consecutive cycles, with no writes and ifm_valid ignored.
REQ-026 After the last FLUSH read, done SHALL be 1 for exactly one cycle and the FSM SHALL enter IDLE.
REQ-027 fifo_wr_inc and fifo_rd_inc SHALL be 1 whenever rst_n=1.
REQ-028 busy SHALL be 1 in FILL, STREAM and FLUSH.
REQ-029 cur_row and cur_col SHALL hold their last values in IDLE until the next start.
REQ-030 ifm_valid=0 in FILL or STREAM SHALL stall the counters with no enables generated; bubbles SHALL NOT corrupt alignment.
REQ-031 num_rows=0 SHALL be treated as 1.
REQ-032 Counters SHALL wrap modulo their width with no saturation logic.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE; all outputs 0, including fifo_*_inc, fifo_*_clr and fifo_data; counters 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without a done pulse.
REQ-035 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-036 IFM_WIDTH=4, num_rows=3, start, then 12 back-to-back valid pixels 1..12 -> 12 wr_en; rd_en for pixels 5..12 plus 4 FLUSH cycles; done one cycle after the last FLUSH read; busy=0 afterwards.
REQ-037 Same frame with ifm_valid toggled 1,0,1,0 -> identical wr_en/rd_en counts; fifo_data sequence 1..12 each lagging its wr_en by one cycle.
REQ-038 num_rows=1, 4 pixels -> FILL goes directly to FLUSH; 4 rd_en; done.
REQ-039 start pulsed during STREAM -> no clr pulse; row/col unaffected.
REQ-040 rst_n low at row 1, col 2 -> all outputs 0 immediately; no done; a new start then runs a full frame correctly.
